// File: rtl/chord_gate_mixer.sv
// rtl/chord_gate_mixer.sv - gate conditioning, voice register file and saturating sample mixer
// Optional build macro: MIX_ATTENUATE_EN (mix output = accumulator >>> clog2(NUM_VOICES))
module chord_gate_mixer #(
  parameter int NUM_VOICES      = 3,
  parameter int DATA_BITS       = 12,
  parameter int FREQ_BITS       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int GATE_ACTIVE_LOW = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            gate_pin,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0]   wr_addr,
  input  logic [FREQ_BITS:0]              wr_data,
  output logic [NUM_VOICES*FREQ_BITS-1:0] tone_freq,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic                            gate,
  output logic                            gate_rise,
  output logic                            gate_fall,
  input  logic                            sample_tick,
  input  logic [NUM_VOICES*DATA_BITS-1:0] voice_data,
  output logic [DATA_BITS-1:0]            dout,
  output logic                            dout_valid,
  output logic                            overrun
);

  localparam int   IW       = $clog2(NUM_VOICES);
  localparam int   AW       = DATA_BITS + IW;
  localparam int   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic PIN_IDLE = (GATE_ACTIVE_LOW != 0);

`ifndef MIX_ATTENUATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DATA_BITS - 1)));
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  // gate path state
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gate_q, gate_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          lvl;

  // register file state
  logic [FREQ_BITS-1:0]  freq_q [NUM_VOICES];
  logic [FREQ_BITS-1:0]  freq_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q, en_d;

  // mixer state
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [DATA_BITS-1:0]  hold_q [NUM_VOICES];
  logic [DATA_BITS-1:0]  hold_d [NUM_VOICES];
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_BITS-1:0]  cur;

  // synchronise the pin, normalise polarity and debounce into a clean gate with edge pulses
  always_comb begin
    sync_d = {sync_q[0], gate_pin};
    lvl    = sync_q[1] ^ PIN_IDLE;
    gate_d = gate_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (lvl == gate_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      gate_d = lvl;
      cnt_d  = '0;
      rise_d = lvl;
      fall_d = ~lvl;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // per-voice frequency/enable writes; out-of-range addresses are dropped
  always_comb begin
    freq_d = freq_q;
    en_d   = en_q;
    if (wr_en && (int'(wr_addr) < NUM_VOICES)) begin
      freq_d[wr_addr] = wr_data[FREQ_BITS-1:0];
      en_d[wr_addr]   = wr_data[FREQ_BITS];
    end
  end

  // mix pass: capture samples, accumulate one voice per clock, then limit and emit
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    hold_d    = hold_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    cur       = hold_q[idx_q];
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            hold_d[i] = voice_data[i*DATA_BITS +: DATA_BITS];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sample_tick) overrun_d = 1'b1;
        if (en_q[idx_q]) acc_d = acc_q + {{IW{cur[DATA_BITS-1]}}, cur};
        if (idx_q == IW'(NUM_VOICES - 1)) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      OUT: begin
        if (sample_tick) overrun_d = 1'b1;
`ifdef MIX_ATTENUATE_EN
        dout_d = DATA_BITS'(acc_q >>> IW);
`else
        if (acc_q > SAT_MAX) begin
          dout_d = SAT_MAX[DATA_BITS-1:0];
        end else if (acc_q < SAT_MIN) begin
          dout_d = SAT_MIN[DATA_BITS-1:0];
        end else begin
          dout_d = acc_q[DATA_BITS-1:0];
        end
`endif
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset aborts any pass in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {2{PIN_IDLE}};
      cnt_q     <= '0;
      gate_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      en_q      <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      gate_q    <= gate_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      en_q      <= en_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq_q[i] <= freq_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  // pack per-voice frequencies, voice 0 in the LSBs
  always_comb begin
    tone_freq = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      tone_freq[i*FREQ_BITS +: FREQ_BITS] = freq_q[i];
    end
  end

  assign voice_gate = en_q & {NUM_VOICES{gate_q}};
  assign gate       = gate_q;
  assign gate_rise  = rise_q;
  assign gate_fall  = fall_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule
